// File: rtl/ofs_plat_axi_stream_pkg.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_stream_pkg
//
// Shared types and constants for the AXI stream platform blocks.
//   t_ofs_plat_axis_skid_state - occupancy of the two-entry skid buffer
//   OFS_PLAT_AXIS_STAT_WIDTH   - width of the optional beat/packet counters
// ----------------------------------------------------------------------------
package ofs_plat_axi_stream_pkg;

    localparam int OFS_PLAT_AXIS_STAT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } t_ofs_plat_axis_skid_state;

endpackage

// File: rtl/ofs_plat_axi_stream_if.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_stream_if
//
// AXI stream interface: a valid/ready handshake plus a payload t, which
// carries data, last and user.
//   Parameters: TDATA_WIDTH, TUSER_WIDTH
//   Modports:   to_sink   - drives tvalid/t, receives tready
//               to_source - receives tvalid/t, drives tready
//
// This file also defines OFS_PLAT_AXI_STREAM_IF_CHECK_PARAMS_MATCH(a, b).
// A module uses it to compare the payload parameters of two interface
// ports. If the parameters differ, elaboration stops with a fatal error.
// ----------------------------------------------------------------------------
`ifndef OFS_PLAT_AXI_STREAM_IF_CHECK_PARAMS_MATCH
`define OFS_PLAT_AXI_STREAM_IF_CHECK_PARAMS_MATCH(a, b) \
    if ((a.TDATA_WIDTH != b.TDATA_WIDTH) || (a.TUSER_WIDTH != b.TUSER_WIDTH)) begin : axis_param_mismatch \
        $fatal(1, "AXI stream interface parameter mismatch between a and b"); \
    end
`endif

interface ofs_plat_axi_stream_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TUSER_WIDTH = 8
);

    typedef struct packed {
        logic                   last;
        logic [TUSER_WIDTH-1:0] user;
        logic [TDATA_WIDTH-1:0] data;
    } t_payload;

    logic     tvalid;
    logic     tready;
    t_payload t;

    modport to_sink (
        output tvalid,
        output t,
        input  tready
    );

    modport to_source (
        input  tvalid,
        input  t,
        output tready
    );

endinterface

// File: rtl/ofs_plat_axi_stream_skid_stats.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_stream_skid_stats
//
// Counts the beats and packets that the sink accepts at the output of the
// skid buffer. Both counters wrap modulo 2^OFS_PLAT_AXIS_STAT_WIDTH.
//   clk        block clock
//   reset      asynchronous, active-high reset
//   out_fire   the sink accepted a beat in this cycle
//   out_last   the accepted beat has last set
//   stat_beats running count of accepted beats
//   stat_pkts  running count of accepted beats with last set
// ----------------------------------------------------------------------------
module ofs_plat_axi_stream_skid_stats
    import ofs_plat_axi_stream_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                out_fire,
    input  logic                                out_last,
    output logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] stat_beats,
    output logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] stat_pkts
);

    logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] beat_cnt;
    logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] pkt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (out_fire) begin
            beat_cnt <= beat_cnt + OFS_PLAT_AXIS_STAT_WIDTH'(1);
            if (out_last) begin
                pkt_cnt <= pkt_cnt + OFS_PLAT_AXIS_STAT_WIDTH'(1);
            end
        end
    end

    assign stat_beats = beat_cnt;
    assign stat_pkts  = pkt_cnt;

endmodule

// File: rtl/ofs_plat_axi_stream_if_skid.sv
// ----------------------------------------------------------------------------
// ofs_plat_axi_stream_if_skid
//
// Registered, fully pipelined connection between two AXI stream interfaces.
// tvalid, the payload and the returned tready all come straight from flops,
// so no combinational path runs through the block in either direction. The
// block holds up to two beats and can pass one beat per cycle.
//
//   clk           block clock
//   reset         asynchronous, active-high reset
//   stream_sink   downstream side (drives tvalid/t, receives tready)
//   stream_source upstream side (receives tvalid/t, drives tready)
//   stat_beats    beats accepted by the sink (0 unless stats are enabled)
//   stat_pkts     beats with last accepted by the sink (0 unless enabled)
//
// Define the macro OFS_PLAT_AXI_STREAM_SKID_STATS_EN to build the stat
// counters.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | main invalid, skid invalid
// ONE   | main valid (presented to sink), skid invalid
// FULL  | main valid, skid holds the next beat
// ----------------------------------------------------------------------------
module ofs_plat_axi_stream_if_skid
    import ofs_plat_axi_stream_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    ofs_plat_axi_stream_if.to_sink              stream_sink,
    ofs_plat_axi_stream_if.to_source            stream_source,
    output logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] stat_beats,
    output logic [OFS_PLAT_AXIS_STAT_WIDTH-1:0] stat_pkts
);

    `OFS_PLAT_AXI_STREAM_IF_CHECK_PARAMS_MATCH(stream_sink, stream_source)

    localparam int PW = stream_sink.TDATA_WIDTH + stream_sink.TUSER_WIDTH + 1;

    t_ofs_plat_axis_skid_state state_q;
    t_ofs_plat_axis_skid_state state_nxt;
    logic                      main_valid_q;
    logic                      tready_q;
    logic [PW-1:0]             main_q;
    logic [PW-1:0]             skid_q;

    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    assign in_fire  = stream_source.tvalid && tready_q;
    assign out_fire = main_valid_q && stream_sink.tready;

    always_comb begin
        state_nxt      = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // tready is low in FULL, so only the drain path applies
                if (out_fire) begin
                    state_nxt      = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // tready is low while reset is high. It rises on the first clock after
    // reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            tready_q     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            main_valid_q <= (state_nxt != EMPTY);
            tready_q     <= (state_nxt != FULL);
        end
    end

    // The payload registers have no reset. The valid state decides whether
    // their contents mean anything.
    always_ff @(posedge clk) begin
        if (main_load) begin
            main_q <= main_from_skid ? skid_q : stream_source.t;
        end
        if (skid_load) begin
            skid_q <= stream_source.t;
        end
    end

    assign stream_sink.tvalid   = main_valid_q;
    assign stream_sink.t        = main_q;
    assign stream_source.tready = tready_q;

`ifdef OFS_PLAT_AXI_STREAM_SKID_STATS_EN
    ofs_plat_axi_stream_skid_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .out_fire   (out_fire),
        .out_last   (stream_sink.t.last),
        .stat_beats (stat_beats),
        .stat_pkts  (stat_pkts)
    );
`else
    assign stat_beats = '0;
    assign stat_pkts  = '0;
`endif

endmodule

// File: tb/tb_ofs_plat_axi_stream_if_skid.sv
// ----------------------------------------------------------------------------
// tb_ofs_plat_axi_stream_if_skid
//
// Bench for the AXI stream skid buffer. Beats are checked against a
// scoreboard: a beat is pushed when the source handshake completes and is
// popped when the sink handshake completes. Inputs are driven 1 time unit
// after the rising edge, and all sampling happens on the falling edge.
// ----------------------------------------------------------------------------
module tb_ofs_plat_axi_stream_if_skid;

    typedef struct packed {
        logic        last;
        logic [3:0]  user;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;

    ofs_plat_axi_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(4)) src_if ();
    ofs_plat_axi_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(4)) snk_if ();

    ofs_plat_axi_stream_if_skid dut (
        .clk           (clk),
        .reset         (reset),
        .stream_sink   (snk_if),
        .stream_source (src_if),
        .stat_beats    (stat_beats),
        .stat_pkts     (stat_pkts)
    );

    always #5 clk = ~clk;

`ifdef OFS_PLAT_AXI_STREAM_SKID_STATS_EN
    localparam logic [31:0] EXP_BEATS = 32'd12;
    localparam logic [31:0] EXP_PKTS  = 32'd3;
`else
    localparam logic [31:0] EXP_BEATS = 32'd0;
    localparam logic [31:0] EXP_PKTS  = 32'd0;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    out_cnt  = 0;
    int    sent_cnt = 0;
    int    max_occ  = 0;
    bit    chk_lat  = 1'b0;
    beat_t tx_q[$];
    exp_t  exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [31:0] d, input logic [3:0] u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        return b;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (snk_if.tvalid && snk_if.tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat", {snk_if.t.last, snk_if.t.user, snk_if.t.data}, e.b);
                    if (chk_lat) check_eq("latency", cyc - e.cyc, 1);
                end
                out_cnt++;
            end
            if (src_if.tvalid && src_if.tready) begin
                e.b.data = src_if.t.data;
                e.b.user = src_if.t.user;
                e.b.last = src_if.t.last;
                e.cyc    = cyc;
                exp_q.push_back(e);
            end
            if (exp_q.size() > max_occ) max_occ = exp_q.size();
        end
    end

    // Runs one clock cycle. On return, time is 1 unit past the next rising
    // edge. rdy is the source tready value seen at the falling edge.
    task automatic cycle(input logic v, input logic r, output logic rdy);
        if (tx_q.size() > 0) begin
            src_if.tvalid = v;
            src_if.t.data = tx_q[0].data;
            src_if.t.user = tx_q[0].user;
            src_if.t.last = tx_q[0].last;
        end else begin
            src_if.tvalid = 1'b0;
        end
        snk_if.tready = r;
        @(negedge clk);
        rdy = src_if.tready;
        if (src_if.tvalid && src_if.tready) begin
            void'(tx_q.pop_front());
            sent_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_sent(input int budget, input bit rnd);
        logic rdy;
        int   k;
        k = 0;
        while (tx_q.size() > 0 && k < budget) begin
            if (rnd) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
            else     cycle(1'b1, 1'b1, rdy);
            k++;
        end
        check_eq("send_budget", tx_q.size(), 0);
    endtask

    task automatic drain(input int budget);
        logic rdy;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            cycle(1'b0, 1'b1, rdy);
            k++;
        end
        check_eq("drain_budget", exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tx_q.delete();
        exp_q.delete();
        src_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        int   out0;
        int   acc;
        int   d;

        reset         = 1'b1;
        src_if.tvalid = 1'b0;
        src_if.t      = '0;
        snk_if.tready = 1'b0;

        // Values while reset is held
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sink_tvalid", snk_if.tvalid, 0);
        check_eq("rst_src_tready", src_if.tready, 0);
        check_eq("rst_stat_beats", stat_beats, 0);
        check_eq("rst_stat_pkts", stat_pkts, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_src_tready", src_if.tready, 1);
        check_eq("post_rst_sink_tvalid", snk_if.tvalid, 0);

        // Back-to-back 0x1..0x8 with the sink always ready
        for (int i = 1; i <= 8; i++) tx_q.push_back(mk_beat(32'(i), 4'(i), (i == 8)));
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, rdy);
            check_eq("t1_src_tready", rdy, 1);
        end
        check_eq("t1_throughput", tx_q.size(), 0);
        drain(8);
        chk_lat = 1'b0;

        // Sink stalls for 4 cycles starting at cycle 5
        out0 = out_cnt;
        acc  = 0;
        for (int k = 0; k < 32; k++) tx_q.push_back(mk_beat(32'h100 + 32'(k), 4'(k), (k % 8 == 7)));
        for (int i = 0; i < 13; i++) begin
            d = sent_cnt;
            cycle(1'b1, !(i >= 5 && i < 9), rdy);
            check_eq($sformatf("t2_tready_c%0d", i), rdy, (i <= 5 || i >= 10));
            if (i >= 5 && i < 9) acc += sent_cnt - d;
        end
        check_eq("t2_stall_accepts", acc, 1);
        run_until_sent(100, 1'b0);
        drain(10);
        check_eq("t2_delivered", out_cnt - out0, 32);

        // Random valid/ready, 10k beats
        out0    = out_cnt;
        max_occ = 0;
        for (int k = 0; k < 10000; k++)
            tx_q.push_back(mk_beat(32'h10000 + 32'(k), 4'($urandom), 1'($urandom)));
        run_until_sent(60000, 1'b1);
        drain(10);
        check_eq("t3_delivered", out_cnt - out0, 10000);
        check_eq("t3_occupancy_over_2", (max_occ > 2), 0);

        // Fill the buffer to FULL, then assert reset
        for (int k = 0; k < 6; k++) tx_q.push_back(mk_beat(32'h200 + 32'(k), 4'hC, 1'b0));
        cycle(1'b1, 1'b1, rdy);
        cycle(1'b1, 1'b1, rdy);
        cycle(1'b1, 1'b0, rdy);
        cycle(1'b1, 1'b0, rdy);
        check_eq("t4_full_sink_tvalid", snk_if.tvalid, 1);
        check_eq("t4_full_src_tready", src_if.tready, 0);
        reset = 1'b1;
        #1;
        check_eq("t4_rst_sink_tvalid", snk_if.tvalid, 0);
        check_eq("t4_rst_src_tready", src_if.tready, 0);
        tx_q.delete();
        exp_q.delete();
        src_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out0  = out_cnt;
        tx_q.push_back(mk_beat(32'hA5, 4'h5, 1'b1));
        run_until_sent(10, 1'b0);
        drain(5);
        check_eq("t4_alone", out_cnt - out0, 1);

        // Packets of 4, 1 and 7 beats for the stat counters
        reset_dut();
        check_eq("t5_rst_beats", stat_beats, 0);
        for (int k = 0; k < 4; k++) tx_q.push_back(mk_beat(32'h300 + 32'(k), 4'h1, (k == 3)));
        tx_q.push_back(mk_beat(32'h310, 4'h2, 1'b1));
        for (int k = 0; k < 7; k++) tx_q.push_back(mk_beat(32'h320 + 32'(k), 4'h3, (k == 6)));
        run_until_sent(200, 1'b1);
        drain(10);
        check_eq("t5_stat_beats", stat_beats, EXP_BEATS);
        check_eq("t5_stat_pkts", stat_pkts, EXP_PKTS);

`ifdef OFS_PLAT_AXI_STREAM_SKID_STATS_EN
        force dut.u_stats.beat_cnt = 32'hFFFF_FFFF;
        force dut.u_stats.pkt_cnt  = 32'hFFFF_FFFF;
        #1;
        release dut.u_stats.beat_cnt;
        release dut.u_stats.pkt_cnt;
`endif
        tx_q.push_back(mk_beat(32'h400, 4'h4, 1'b1));
        run_until_sent(10, 1'b0);
        drain(5);
        check_eq("t5_wrap_beats", stat_beats, 0);
        check_eq("t5_wrap_pkts", stat_pkts, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofs_plat_axi_stream_if_skid.md
# ofs_plat_axi_stream_if_skid

Registered, fully pipelined connection between two AXI stream interface instances. Every forward signal (tvalid, payload) and the backward tready are flopped, so neither combinational path crosses the block. It holds up to two beats, sustains one beat per cycle, and is inserted where a direct source-to-sink wiring would close timing poorly, such as a long route between the FIU edge and AFU logic.

## Interface
- No module parameters. Payload widths (TDATA_WIDTH, TUSER_WIDTH) come from the two interface instances and must match.
- clk  input  1  block clock; both interfaces are synchronous to it.
- reset  input  1  asynchronous, active-high reset.
- stream_sink  ofs_plat_axi_stream_if.to_sink  —  downstream side; block drives tvalid and t (data, last, user), receives tready.
- stream_source  ofs_plat_axi_stream_if.to_source  —  upstream side; block receives tvalid and t, drives tready.
- stat_beats  output  32  count of beats accepted by the sink.
- stat_pkts  output  32  count of beats with last=1 accepted by the sink.

## Operation
- Storage is two payload registers:
  - main: drives stream_sink.t and stream_sink.tvalid.
  - skid: overflow entry.
- Occupancy state machine:
  - EMPTY(0): main invalid, skid invalid.
  - ONE(1): main valid, skid invalid.
  - FULL(2): main valid, skid valid.
- Handshake events:
  - in = stream_source.tvalid && stream_source.tready.
  - out = stream_sink.tvalid && stream_sink.tready.
- Transitions:
  - EMPTY: in → ONE, beat loaded into main.
  - ONE: in && !out → FULL, beat into skid. in && out → ONE, new beat into main. !in && out → EMPTY.
  - FULL: out → ONE, skid moves to main. in cannot occur in FULL because tready=0.
- stream_source.tready is a register and equals (next state != FULL).
- Beats leave in arrival order. No beat is dropped or duplicated.
- Payload is passed bit-exact, including last and user.
- Payload registers need no reset. Valid bits, state and tready are reset.
- Reset mid-operation: any held beats are discarded. The block returns to EMPTY on the next clock after reset deasserts, regardless of in-flight handshakes.
- Sink tready may drop at any time, including mid-packet. Source tvalid may drop between beats. Neither case is a protocol error.
- A parameter mismatch between the two interfaces is a simulation-only fatal error, reported at time 0.

## Timing
- Reset values:
  - stream_sink.tvalid = 0.
  - stream_source.tready = 1. It is asserted from the first post-reset edge, and is 0 while reset is high.
  - stat_beats = 0, stat_pkts = 0.
- Latency: a beat accepted at edge N is presented on stream_sink at edge N+1.
- Throughput: 1 beat/cycle whenever sink tready stays high.
- Backpressure: after sink tready falls, the block accepts at most one more beat. Source tready is low one cycle after the skid entry fills.
- Recovery: tready returns high one cycle after sink tready reasserts in FULL.

## Configuration
- OFS_PLAT_AXI_STREAM_SKID_STATS_EN defined:
  - stat_beats increments on every out event.
  - stat_pkts increments on every out event with t.last=1.
  - Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both stat ports are tied to constant 0 and no counter logic is built.

## Structure
- Add to ofs_plat_axi_stream_pkg:
  - skid occupancy enum t_ofs_plat_axis_skid_state {EMPTY, ONE, FULL}.
  - the stats width constant OFS_PLAT_AXIS_STAT_WIDTH=32.
- One natural sub-module: ofs_plat_axi_stream_skid_stats, holding the two counters. It is instantiated only under the macro.
- Parameter-match checking uses the existing stream interface check macro.

## Test plan
- Reset, then source sends data 0x1..0x8 back-to-back, sink tready=1 → sink sees 0x1..0x8 one cycle after each accept, 1 beat/cycle, source tready never drops.
- Stream running; sink tready=0 at cycle 5 for 4 cycles → exactly one extra beat accepted, source tready low from cycle 6. After release, order intact and no loss.
- Random source tvalid and sink tready (50% each) for 10k beats with incrementing data → scoreboard exact, state never exceeds FULL.
- Reset asserted while FULL → sink tvalid=0 and source tready=0 immediately. After deassert, first new beat 0xA5 delivered alone.
- Macro defined: 3 packets of 4, 1 and 7 beats → stat_beats=12, stat_pkts=3. Preload near 2^32-1 by force → wraps to 0.
- Macro undefined: same traffic → stat_beats=stat_pkts=0 throughout.
